// File: rtl/line_serializer.sv
// rtl/line_serializer.sv - write-back serializer: one cache line out as WORDS word beats
module line_serializer #(
   parameter int WORDS  = 8,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32,
   parameter int LINE_W = WORDS * WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LINE_W-1:0] line_in,
   input  logic [ADDR_W-1:0] line_addr,
   output logic              busy,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_data,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   output logic              done
);

   // byte offset bits inside one line; forced to zero in the captured base
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int CNT_W = $clog2(WORDS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [LINE_W-1:0]   line_q;
   logic [ADDR_W-1:0]   base_q;
   logic [CNT_W-1:0]    nxt;
   logic [ADDR_W-1:0]   line_base;
   logic                unused_low_addr;

   // line-aligned base of the incoming address and index of the following beat
   always_comb begin
      line_base = {line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      nxt       = cnt + 1'b1;
   end

   assign unused_low_addr = &{1'b0, line_addr[OFF_W-1:0]};

   // control FSM; beat data/address are preloaded so every output comes from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         line_q   <= '0;
         base_q   <= '0;
         busy     <= 1'b0;
         mem_we   <= 1'b0;
         done     <= 1'b0;
         mem_data <= '0;
         mem_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  line_q   <= line_in;
                  base_q   <= line_base;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  mem_we   <= 1'b1;
                  mem_data <= line_in[WORD_W-1:0];
                  mem_addr <= line_base;
                  state    <= S_SEND;
               end
            end
            S_SEND: begin
               if (mem_ready) begin
                  if (cnt == LAST) begin
                     cnt    <= '0;
                     mem_we <= 1'b0;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     cnt      <= nxt;
                     mem_data <= line_q[nxt*WORD_W +: WORD_W];
                     mem_addr <= base_q + {{(ADDR_W-CNT_W-2){1'b0}}, nxt, 2'b00};
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               busy   <= 1'b0;
               mem_we <= 1'b0;
               done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_serializer.sv
// tb/tb_line_serializer.sv - randomized bench for line_serializer against a beat-queue model
module tb_line_serializer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [255:0] line_in = '0;
   logic [31:0]  line_addr = '0;
   logic         busy;
   logic         mem_we;
   logic [31:0]  mem_data;
   logic [31:0]  mem_addr;
   logic         mem_ready = 1'b0;
   logic         done;

   int total = 0;
   int bad   = 0;

   // model: beats still owed to memory, and whether a done cycle is due
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   bit          done_due = 1'b0;

   line_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .line_in   (line_in),
      .line_addr (line_addr),
      .busy      (busy),
      .mem_we    (mem_we),
      .mem_data  (mem_data),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // compare outputs for the current cycle, then drive inputs for the next edge
   task automatic step(input logic s, input logic r, input logic rs,
                       input logic [255:0] l, input logic [31:0] a);
      logic [31:0] base;
      @(negedge clk);
      if (exp_addr_q.size() > 0) begin
         chk("we", {31'b0, mem_we}, 32'd1);
         chk("busy", {31'b0, busy}, 32'd1);
         chk("done", {31'b0, done}, 32'd0);
         chk("data", mem_data, exp_data_q[0]);
         chk("addr", mem_addr, exp_addr_q[0]);
      end else if (done_due) begin
         chk("we_done", {31'b0, mem_we}, 32'd0);
         chk("busy_done", {31'b0, busy}, 32'd1);
         chk("done_pulse", {31'b0, done}, 32'd1);
      end else begin
         chk("we_idle", {31'b0, mem_we}, 32'd0);
         chk("busy_idle", {31'b0, busy}, 32'd0);
         chk("done_idle", {31'b0, done}, 32'd0);
      end
      start     = s;
      mem_ready = r;
      rst       = rs;
      line_in   = l;
      line_addr = a;
      if (rs) begin
         exp_addr_q.delete();
         exp_data_q.delete();
         done_due = 1'b0;
      end else if (exp_addr_q.size() > 0) begin
         if (r) begin
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
            if (exp_addr_q.size() == 0) done_due = 1'b1;
         end
      end else if (done_due) begin
         done_due = 1'b0;
      end else if (s) begin
         base = a & 32'hFFFF_FFE0;
         for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            exp_data_q.push_back(l[32*i +: 32]);
         end
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   logic [255:0] seq_line;

   initial begin
      for (int i = 0; i < 8; i++) seq_line[32*i +: 32] = 32'h1111_1111 * (i + 1);

      // reset state
      @(negedge clk);
      chk("rst_data", mem_data, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      step(0, 0, 1, '0, '0);

      // basic write-back, ready throughout
      step(1, 1, 0, seq_line, 32'h0000_1000);
      for (int i = 0; i < 11; i++) step(0, 1, 0, '0, '0);

      // backpressure for three cycles on beat 2
      step(1, 1, 0, seq_line, 32'h0000_1000);
      step(0, 1, 0, '0, '0);
      step(0, 1, 0, '0, '0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0);
      for (int i = 0; i < 9; i++) step(0, 1, 0, '0, '0);

      // misaligned address, inputs change after the accepting edge
      step(1, 1, 0, seq_line, 32'h0000_2013);
      for (int i = 0; i < 11; i++) step(0, 1, 0, rand_line(), $urandom);

      // start held high: second transfer only after the idle cycle
      for (int i = 0; i < 24; i++) step(1, 1, 0, seq_line, 32'h0000_3000 + 32'(i));
      for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0);

      // reset after beat 4 accepted, then a fresh transfer
      step(1, 1, 0, seq_line, 32'h0000_1000);
      for (int i = 0; i < 5; i++) step(0, 1, 0, '0, '0);
      step(0, 1, 1, '0, '0);
      step(0, 1, 0, '0, '0);
      step(1, 1, 0, seq_line, 32'h0000_4000);
      for (int i = 0; i < 11; i++) step(0, 1, 0, '0, '0);

      // address wrap at the top of the address space
      step(1, 1, 0, seq_line, 32'hFFFF_FFE0);
      for (int i = 0; i < 11; i++) step(0, 1, 0, '0, '0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3F)) : $urandom;
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 199) == 0, rand_line(), a);
      end
      for (int i = 0; i < 40; i++) step(0, 1, 0, '0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_serializer.md
Name: line_serializer

Overview:
- Write-back stage of the cache-to-memory path; the counterpart of the fill-side deserializer.
- Accepts one 256-bit dirty cache line plus its line address from the cache controller.
- Emits the line to memory as 8 sequential 32-bit word beats, using a valid/ready handshake with word addresses.
- Pulses done when the final beat has been accepted, so the controller can proceed to the refill.

Parameters:
- WORDS, 8, number of 32-bit beats per line; LINE_W = WORDS*WORD_W.
- WORD_W, 32, beat data width in bits.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to write back line_in; sampled only in IDLE.
- line_in  input  LINE_W  line data; word i occupies bits [32i+31:32i].
- line_addr  input  ADDR_W  byte address of the line; low 5 bits ignored.
- busy  output  1  high in SEND and DONE.
- mem_we  output  1  beat valid (memory write strobe).
- mem_data  output  WORD_W  current beat data.
- mem_addr  output  ADDR_W  current beat byte address.
- mem_ready  input  1  memory accepts the beat this cycle.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE; beat counter=0; busy=0; mem_we=0; done=0; mem_data=0; mem_addr=0. Captured line and address registers are cleared to 0.
- States:
  - IDLE: start=1 captures line_in into the line register, and line_addr with [4:0] forced to 0 into the base register. Counter clears to 0. Next state is SEND. start=0 stays in IDLE.
  - SEND: mem_we=1. mem_data = captured word[counter]. mem_addr = base + 4*counter, computed in ADDR_W bits modulo 2^ADDR_W. A beat transfers when mem_we && mem_ready.
    - On transfer with counter<7: counter increments.
    - On transfer with counter==7: next state is DONE and counter returns to 0.
    - With mem_ready=0: mem_we, mem_data and mem_addr hold stable. There is no timeout.
  - DONE: done=1 and mem_we=0 for exactly one cycle; next state is IDLE.
- Latency:
  - start is seen in IDLE at edge N; beat 0 is presented from cycle N+1.
  - With mem_ready held at 1, beats occupy cycles N+1..N+8, done is high in cycle N+9, and start can be accepted again at edge N+10.
- Data capture:
  - line_in and line_addr are sampled only on the accepting edge.
  - Later changes to either input do not affect an in-flight transfer.
- start ignored: start while in SEND or DONE is ignored, not queued.
- Word order: word 0 (bits 31:0) goes first at the lowest address. This matches the fill-side deserializer, so a line written back and refilled reassembles identically.
- Reset mid-operation: rst=1 in any state returns to IDLE on that edge. mem_we and done are 0 in the next cycle, and the remaining beats are abandoned.
- Simultaneous events:
  - rst overrides start and mem_ready.
  - mem_ready while mem_we=0 has no effect.
- Output timing: all outputs are registered or decoded from registered state only; there is no combinational path from mem_ready to mem_we.

Test Plan:
- Basic write-back: line words 0..7 = 0x11111111..0x88888888, line_addr=0x0000_1000, start pulse, mem_ready=1 throughout -> 8 beats in consecutive cycles at addrs 0x1000,0x1004,...,0x101C with data 0x11111111..0x88888888. done pulse one cycle after the last beat; busy falls the cycle after that.
- Backpressure: same line, mem_ready=0 for 3 cycles during beat 2 -> mem_we/mem_data=0x33333333/mem_addr=0x1008 are held for those 3 cycles; total transfer spans 11 cycles; done still a single pulse.
- Misaligned address and input change: line_addr=0x0000_2013, then line_in and line_addr change on the cycle after start -> beats still carry the captured data at addrs 0x2000..0x201C.
- start ignored while busy: start=1 held high through the whole transfer -> exactly 8 beats, then 1 done cycle. A second transfer begins only after the IDLE cycle that follows done.
- Reset mid-transfer: rst asserted after beat 4 is accepted -> next cycle mem_we=0, busy=0, done=0. A new start sends beat 0 at base+0 (counter restarted).
- Address wrap: line_addr=0xFFFF_FFE0 -> last beat addr 0xFFFF_FFFC; no overflow into other signals.
